// File: rtl/arith_pkg.sv
// Shared arithmetic-library definitions: FSM state encodings and default operand width.
package arith_pkg;

    localparam int ARITH_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_cell.sv
// One-bit full subtractor: difference and borrow-out for a - b - bin.
module full_subtractor_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: computes A - B one bit per clock with a registered
// borrow, streaming each difference bit and presenting the parallel result on completion.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = ARITH_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             D_BIT,
    output logic             D_VALID,
    output logic [WIDTH-1:0] DIFF,
    output logic             Bout,
    output logic             DONE
);

    localparam int              CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state_r;
    state_t             state_s;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   res_r;
    logic [WIDTH-1:0]   diff_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               br_r;
    logic               busy_r;
    logic               valid_r;
    logic               done_r;
    logic               bout_r;
    logic               d_s;
    logic               bout_s;
    logic               last_s;

    full_subtractor_cell u_cell (
        .a    (a_r[0]),
        .b    (b_r[0]),
        .bin  (br_r),
        .d    (d_s),
        .bout (bout_s)
    );

    assign last_s = (cnt_r == CNT_LAST);

    // Next-state logic; the unused encoding falls back to IDLE.
    always_comb begin
        state_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (START) begin
                    state_s = ST_SHIFT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (last_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand/result datapath and status flags, registered from the next state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            a_r     <= '0;
            b_r     <= '0;
            res_r   <= '0;
            diff_r  <= '0;
            cnt_r   <= '0;
            br_r    <= 1'b0;
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
            done_r  <= 1'b0;
            bout_r  <= 1'b0;
        end else begin
            busy_r  <= (state_s != ST_IDLE);
            valid_r <= (state_s == ST_SHIFT);
            done_r  <= (state_s == ST_DONE);
            case (state_r)
                ST_IDLE: begin
                    if (START) begin
                        a_r    <= A;
                        b_r    <= B;
                        res_r  <= '0;
                        diff_r <= '0;
                        cnt_r  <= '0;
                        br_r   <= 1'b0;
                        bout_r <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    a_r   <= {1'b0, a_r[WIDTH-1:1]};
                    b_r   <= {1'b0, b_r[WIDTH-1:1]};
                    res_r <= {d_s, res_r[WIDTH-1:1]};
                    br_r  <= bout_s;
                    cnt_r <= cnt_r + CNT_W'(1);
                    // Capture the completed word on the final shift so it is valid alongside DONE.
                    if (last_s) begin
                        diff_r <= {d_s, res_r[WIDTH-1:1]};
                        bout_r <= bout_s;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign BUSY    = busy_r;
    assign D_VALID = valid_r;
    assign D_BIT   = valid_r & d_s;
    assign DONE    = done_r;
    assign DIFF    = diff_r;
    assign Bout    = bout_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed scenarios plus random traffic,
// compared every cycle against an operation-level reference model.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         START = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         BUSY;
    logic         D_BIT;
    logic         D_VALID;
    logic [W-1:0] DIFF;
    logic         Bout;
    logic         DONE;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    serial_subtractor #(.WIDTH(W)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .START   (START),
        .A       (A),
        .B       (B),
        .BUSY    (BUSY),
        .D_BIT   (D_BIT),
        .D_VALID (D_VALID),
        .DIFF    (DIFF),
        .Bout    (Bout),
        .DONE    (DONE)
    );

    always #5 CLK = ~CLK;

    // Reference model: m_ph is -1 when idle, 0..W-1 while bit m_ph streams, W for the done cycle.
    int           m_ph = -1;
    logic [W-1:0] m_a = '0;
    logic [W-1:0] m_b = '0;
    logic [W-1:0] m_diff = '0;
    logic         m_bout = 1'b0;
    logic [W-1:0] m_full;

    assign m_full = m_a - m_b;

    always @(posedge CLK) begin
        if (RST) begin
            m_ph   <= -1;
            m_diff <= '0;
            m_bout <= 1'b0;
        end else if (m_ph < 0) begin
            if (START) begin
                m_ph   <= 0;
                m_a    <= A;
                m_b    <= B;
                m_diff <= '0;
                m_bout <= 1'b0;
            end
        end else if (m_ph < W) begin
            m_ph <= m_ph + 1;
            if (m_ph == W - 1) begin
                m_diff <= m_full;
                m_bout <= (m_a < m_b);
            end
        end else begin
            m_ph <= -1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    logic e_valid;
    logic e_bit;
    assign e_valid = (m_ph >= 0) && (m_ph < W);
    assign e_bit   = e_valid ? m_full[m_ph[2:0]] : 1'b0;

    always @(negedge CLK) begin
        if (chk_en) begin
            check_eq("busy",    32'(BUSY),    32'(m_ph >= 0));
            check_eq("d_valid", 32'(D_VALID), 32'(e_valid));
            check_eq("d_bit",   32'(D_BIT),   32'(e_bit));
            check_eq("done",    32'(DONE),    32'(m_ph == W));
            check_eq("diff",    32'(DIFF),    32'(m_diff));
            check_eq("bout",    32'(Bout),    32'(m_bout));
        end
    end

    task automatic step(input logic s, input logic [W-1:0] a, input logic [W-1:0] b, input logic r);
        @(negedge CLK);
        START = s;
        A     = a;
        B     = b;
        RST   = r;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, W'($urandom), W'($urandom), 1'b0);
        end
    endtask

    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b);
        step(1'b1, a, b, 1'b0);
        idle(W + 1);
    endtask

    initial begin
        @(posedge CLK);
        #1 chk_en = 1'b1;
        step(1'b1, 8'hAA, 8'h55, 1'b1);
        step(1'b0, 8'h00, 8'h00, 1'b0);

        op(8'h05, 8'h03);
        op(8'h03, 8'h05);

        // Back-to-back: second START raised on the DONE-cycle edge and held one more edge.
        step(1'b1, 8'h00, 8'h00, 1'b0);
        idle(W);
        step(1'b1, 8'hFF, 8'h01, 1'b0);
        step(1'b1, 8'hFF, 8'h01, 1'b0);
        idle(W + 1);

        // START re-pulses mid-operation are ignored.
        step(1'b1, 8'h9C, 8'h27, 1'b0);
        idle(2);
        step(1'b1, 8'h11, 8'hEE, 1'b0);
        idle(4);
        step(1'b1, 8'h42, 8'h99, 1'b0);
        idle(3);

        // Reset aborts an operation; a fresh START follows.
        step(1'b1, 8'h12, 8'h34, 1'b0);
        idle(3);
        step(1'b0, 8'h00, 8'h00, 1'b1);
        step(1'b0, 8'h00, 8'h00, 1'b0);
        op(8'h80, 8'h01);

        op(8'h00, 8'h01);
        op(8'hFF, 8'hFF);

        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 3) == 0), W'($urandom), W'($urandom),
                 ($urandom_range(0, 59) == 0));
        end
        idle(W + 2);

        @(posedge CLK);
        #2;
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
